// File: rtl/fde_pkg.sv
// fde_pkg: shared opcodes, bus field positions and fetch state for the fetch/decode/execute pipeline
package fde_pkg;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLL  = 6'b000101;
  localparam logic [5:0] OP_SRL  = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000111;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_ST   = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_JMP  = 6'b001100;
  localparam logic [5:0] OP_HLT  = 6'b001101;
  localparam logic [5:0] OP_NOP  = 6'b001110;
  localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'd0};
  localparam int IFID_PC_MSB    = 63;
  localparam int IFID_PC_LSB    = 32;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_INSTR_LSB = 0;
  localparam int EXWB_BR_TAKEN   = 69;
  localparam int EXWB_BR_TGT_MSB = 63;
  localparam int EXWB_BR_TGT_LSB = 32;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} fetch_state_t;
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction
endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: instruction store with synchronous write and combinational (old-data) read
module fetch_imem #(
  parameter int IMEM_DEPTH = 256,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [IMEM_DEPTH];
  // write port; not touched by reset so boot contents survive it
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, local instruction memory and IF_ID register with redirect bubbles, stall and halt
module fetch_unit
  import fde_pkg::*;
#(
  parameter int          IMEM_DEPTH   = 256,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic [70:0]   EX_WB,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_wdata,
  output logic [63:0]   IF_ID,
  output logic          halted
);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  logic [31:0] pc, instr, tgt;
  logic [3:0] cnt;
  logic br;
  fetch_state_t state;
  logic unused_ok;
  assign br  = EX_WB[EXWB_BR_TAKEN];
  assign tgt = EX_WB[EXWB_BR_TGT_MSB:EXWB_BR_TGT_LSB];
  assign unused_ok = ^{EX_WB[70], EX_WB[68:64], EX_WB[31:0], pc[31:AW+2], pc[1:0]};
  fetch_imem #(.IMEM_DEPTH(IMEM_DEPTH)) u_imem (
    .clk  (clock),
    .we   (imem_we),
    .waddr(imem_addr),
    .wdata(imem_wdata),
    .raddr(pc[AW+1:2]),
    .rdata(instr)
  );
  // fetch FSM: the redirect cycle itself emits the first bubble, so FLUSH covers the remaining FLUSH_CYCLES-1
  always_ff @(posedge clock)
    if (reset) begin
      pc     <= RESET_PC;
      IF_ID  <= {RESET_PC, NOP_INSTR};
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else if (br) begin
      pc     <= tgt;
      IF_ID  <= {tgt, NOP_INSTR};
      state  <= FLUSH_CYCLES == 1 ? RUN : FLUSH;
      cnt    <= FLUSH_INIT;
      halted <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        RUN: begin
          IF_ID <= {pc, instr};
          if (opcode_of(instr) == OP_HLT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else pc <= pc + 32'd4;
        end
        FLUSH: begin
          IF_ID <= {pc, NOP_INSTR};
          if (cnt == '0) state <= RUN;
          else cnt <= cnt - 4'd1;
        end
        default: IF_ID <= {pc, NOP_INSTR};
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a cycle-level behavioural model
module tb_fetch_unit;
  localparam int D = 256;
  localparam int FC = 2;
  localparam logic [31:0] NOP = 32'h3800_0000;
  localparam logic [31:0] HLT = 32'h3400_0000;
  typedef struct packed {
    logic [63:0] ifid;
    logic        halted;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1, stall = 1'b0, imem_we = 1'b0;
  logic [70:0] EX_WB = '0;
  logic [7:0] imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [63:0] IF_ID;
  logic halted;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic [31:0] mdl_mem [D];
  logic [31:0] m_pc = 32'h0;
  int m_nops = 0;
  logic m_halt = 1'b0;
  logic [63:0] m_last = {32'h0, NOP};
  fetch_unit #(.IMEM_DEPTH(D), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .EX_WB(EX_WB),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .IF_ID(IF_ID), .halted(halted)
  );
  always #5 clock = ~clock;
  // one cycle of stimulus; the model works from the rules: a redirect buys FC bubbles, HLT parks the PC
  task automatic step(input logic r, input logic st, input logic b, input logic [31:0] tgt,
                      input logic we, input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] ins;
    exp_t e;
    @(negedge clock);
    reset = r; stall = st; imem_we = we; imem_addr = wa; imem_wdata = wd;
    EX_WB = {$urandom, $urandom, $urandom} & ~(71'd1 << 69);
    EX_WB[69] = b;
    EX_WB[63:32] = tgt;
    if (r) begin
      m_pc = 32'h0; m_nops = 0; m_halt = 1'b0; e.ifid = {32'h0, NOP};
    end else if (b) begin
      m_pc = tgt; m_nops = FC - 1; m_halt = 1'b0; e.ifid = {tgt, NOP};
    end else if (st) e.ifid = m_last;
    else if (m_halt || m_nops > 0) begin
      e.ifid = {m_pc, NOP};
      if (m_nops > 0) m_nops--;
    end else begin
      ins = mdl_mem[(m_pc / 4) % D];
      e.ifid = {m_pc, ins};
      if (ins[31:26] == 6'b001101) m_halt = 1'b1;
      else m_pc = m_pc + 4;
    end
    e.halted = m_halt;
    m_last = e.ifid;
    if (we) mdl_mem[wa] = wd;
    q.push_back(e);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask
  task automatic redirect(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b1, t, 1'b0, 8'h0, 32'h0);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom;
    if (v[31:26] == 6'b001101) v[26] = 1'b0;
    return v;
  endfunction
  // monitor: every cycle the DUT presents a registered IF_ID, checked against the oldest expectation
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (IF_ID !== e.ifid) begin
        mismatched++;
        $display("FAIL if_id got=%h exp=%h t=%0t", IF_ID, e.ifid, $time);
      end
      compared++;
      if (halted !== e.halted) begin
        mismatched++;
        $display("FAIL halted got=%b exp=%b t=%0t", halted, e.halted, $time);
      end
    end
  end
  initial begin
    logic [31:0] w;
    for (int a = 0; a < D; a++) begin
      w = a == 0 ? 32'h0000_0001 : a == 1 ? 32'h0400_0002 : a == 2 ? 32'h0800_0003 :
          a == 3 ? HLT : rand_instr();
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'(a), w);
    end
    run(3);
    redirect(32'h40);
    run(4);
    redirect(32'h0);
    run(8);
    redirect(32'h0);
    run(3);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    run(1);
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 8'h0, 32'h0);
    run(3);
    redirect(32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    run(3);
    redirect(32'h400);
    run(3);
    redirect(32'hFFFF_FFF8);
    run(5);
    redirect(32'h20);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h8, 32'hDEAD_0001);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h9, 32'h1234_5678);
    run(3);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      logic we;
      t = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4) : $urandom & ~32'h3;
      we = $urandom_range(0, 9) == 0;
      w = $urandom_range(0, 40) == 0 ? HLT : rand_instr();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, t,
           we, 8'($urandom), w);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    #2;
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
